// File: rtl/up_down_mod_counter.sv
// ---------------------------------------------------------------------------
// up_down_mod_counter
//
// General-purpose up/down counter with a programmable top count. One count
// register serves both directions. The direction is picked every cycle by
// select_i. At a boundary the counter either wraps around or holds,
// depending on the SATURATE parameter.
//
// Parameters
//   WIDTH      counter width in bits (>= 2)
//   MAX_VALUE  top count; the counter range is 0..MAX_VALUE
//              (1 <= MAX_VALUE <= 2**WIDTH-1)
//   SATURATE   0 = wrap at the boundaries, 1 = hold at the boundaries
//
// Ports
//   clk_i            clock; all state changes on the rising edge
//   clear_i          synchronous reset, active-low
//   enable_i         1 = take one count step this cycle
//   select_i         direction: 0 = up, 1 = down
//   load_i           1 = load load_value_i this cycle (beats enable_i)
//   load_value_i     value to load; clamped to MAX_VALUE
//   count_value_o    registered count
//   terminal_count_o combinational flag: the count is at the boundary for
//                    the direction currently on select_i
//   wrap_pulse_o     registered; high for the one cycle after a wrap
// ---------------------------------------------------------------------------
module up_down_mod_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_VALUE = (2 ** WIDTH) - 1,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             select_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] count_value_o,
  output logic             terminal_count_o,
  output logic             wrap_pulse_o
);

  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_clamped;

  // Boundary detection always compares against MaxCount. The counter never
  // relies on the natural 2**WIDTH rollover, so a non-power-of-two modulus
  // behaves exactly like the full-range case.
  assign at_max  = (count_q == MaxCount);
  assign at_zero = (count_q == '0);

  // Loaded values above the top count are clamped. This keeps the count
  // inside 0..MAX_VALUE at all times.
  assign load_clamped = (load_value_i > MaxCount) ? MaxCount : load_value_i;

  // Next-state selection. Load beats enable. At a boundary in saturate mode
  // the count simply keeps its value. wrap_d is cleared by default, so a
  // pulse can only come from a real wrap step.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load_i) begin
      count_d = load_clamped;
    end else if (enable_i) begin
      if (!select_i) begin
        if (!at_max) begin
          count_d = count_q + One;
        end else if (!SATURATE) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_d = count_q - One;
        end else if (!SATURATE) begin
          count_d = MaxCount;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  // Single register stage. clear_i is sampled on the clock edge and
  // overrides both load and enable.
  always_ff @(posedge clk_i) begin
    if (!clear_i) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // The terminal flag follows select_i with zero latency. It does not
  // depend on enable_i.
  assign terminal_count_o = select_i ? at_zero : at_max;
  assign count_value_o    = count_q;
  assign wrap_pulse_o     = wrap_q;

endmodule

// File: tb/tb_up_down_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_up_down_mod_counter
//
// Drives three counter instances with the same inputs:
//   dut 0: WIDTH=4, MAX_VALUE=9,  wrap
//   dut 1: WIDTH=4, MAX_VALUE=9,  saturate
//   dut 2: WIDTH=4, MAX_VALUE=15, wrap
// A behavioural model computes each instance's count with plain modular
// arithmetic. The count, terminal flag and wrap pulse are compared on every
// falling edge. Directed scenarios also check hand-worked literal values.
// ---------------------------------------------------------------------------
module tb_up_down_mod_counter;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       enable = 1'b0;
  logic       select = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;

  logic [3:0] cnt [3];
  logic       tc  [3];
  logic       wr  [3];

  int total = 0;
  int bad = 0;

  // Model state, one entry per instance
  int maxv [3] = '{9, 9, 15};
  bit sat  [3] = '{1'b0, 1'b1, 1'b0};
  int mdl  [3] = '{0, 0, 0};
  bit mwr  [3] = '{1'b0, 1'b0, 1'b0};
  bit valid = 1'b0;

  always #5 clk = ~clk;

  up_down_mod_counter #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b0)) dut0 (
    .clk_i(clk), .clear_i(clear), .enable_i(enable), .select_i(select),
    .load_i(load), .load_value_i(load_value),
    .count_value_o(cnt[0]), .terminal_count_o(tc[0]), .wrap_pulse_o(wr[0]));

  up_down_mod_counter #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b1)) dut1 (
    .clk_i(clk), .clear_i(clear), .enable_i(enable), .select_i(select),
    .load_i(load), .load_value_i(load_value),
    .count_value_o(cnt[1]), .terminal_count_o(tc[1]), .wrap_pulse_o(wr[1]));

  up_down_mod_counter #(.WIDTH(4), .MAX_VALUE(15), .SATURATE(1'b0)) dut2 (
    .clk_i(clk), .clear_i(clear), .enable_i(enable), .select_i(select),
    .load_i(load), .load_value_i(load_value),
    .count_value_o(cnt[2]), .terminal_count_o(tc[2]), .wrap_pulse_o(wr[2]));

  // One comparison: counts it, and reports it if it fails
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the range 0..maxv is treated as a ring of maxv+1
  // values. Wrapping is modular arithmetic, and saturating is min/max.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!clear) begin
        mdl[i] = 0;
        mwr[i] = 1'b0;
      end else if (load) begin
        mdl[i] = (int'(load_value) > maxv[i]) ? maxv[i] : int'(load_value);
        mwr[i] = 1'b0;
      end else if (enable && !select) begin
        mwr[i] = !sat[i] && (mdl[i] + 1 > maxv[i]);
        mdl[i] = sat[i] ? ((mdl[i] + 1 > maxv[i]) ? maxv[i] : mdl[i] + 1)
                        : (mdl[i] + 1) % (maxv[i] + 1);
      end else if (enable && select) begin
        mwr[i] = !sat[i] && (mdl[i] - 1 < 0);
        mdl[i] = sat[i] ? ((mdl[i] - 1 < 0) ? 0 : mdl[i] - 1)
                        : (mdl[i] + maxv[i]) % (maxv[i] + 1);
      end else begin
        mwr[i] = 1'b0;
      end
    end
    if (!clear) valid = 1'b1;
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (valid) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("count[%0d]", i), 32'(cnt[i]), 32'(mdl[i]));
        checkOutput($sformatf("wrap[%0d]", i), 32'(wr[i]), 32'(mwr[i]));
        checkOutput($sformatf("tc[%0d]", i), 32'(tc[i]),
                    32'(select ? (mdl[i] == 0) : (mdl[i] == maxv[i])));
      end
    end
  end

  // Set the inputs, then let one rising edge consume them. On return we are
  // 2 time units past that edge, and the inputs are still applied.
  task automatic applyStimulus(input logic c, input logic e, input logic s,
                               input logic l, input logic [3:0] v);
    clear      = c;
    enable     = e;
    select     = s;
    load       = l;
    load_value = v;
    @(posedge clk);
    #2;
  endtask

  int expUp   [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int expDown [4]  = '{1, 0, 9, 8};

  initial begin
    // Scenario 1: reset, then count up 12 times (dut0 wraps 9 -> 0)
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("reset_count", 32'(cnt[0]), 32'd0);
    checkOutput("reset_wrap", 32'(wr[0]), 32'd0);
    checkOutput("reset_tc_up", 32'(tc[0]), 32'd0);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      checkOutput("t1_count", 32'(cnt[0]), 32'(expUp[k]));
      checkOutput("t1_wrap", 32'(wr[0]), (k == 9) ? 32'd1 : 32'd0);
      checkOutput("t1_tc", 32'(tc[0]), (k == 8) ? 32'd1 : 32'd0);
    end
    checkOutput("t1_sat_hold", 32'(cnt[1]), 32'd9);
    checkOutput("t1_mod16", 32'(cnt[2]), 32'd12);

    // Scenario 2: count down from 2 (dut0 wraps 0 -> 9)
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      checkOutput("t2_count", 32'(cnt[0]), 32'(expDown[k]));
      checkOutput("t2_wrap", 32'(wr[0]), (k == 2) ? 32'd1 : 32'd0);
      checkOutput("t2_tc", 32'(tc[0]), (k == 1) ? 32'd1 : 32'd0);
    end

    // Scenario 3: saturation on dut1
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd8);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      checkOutput("t3_sat_up", 32'(cnt[1]), 32'd9);
      checkOutput("t3_sat_up_wrap", 32'(wr[1]), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      checkOutput("t3_sat_down", 32'(cnt[1]), 32'd0);
      checkOutput("t3_sat_down_wrap", 32'(wr[1]), 32'd0);
    end

    // Scenario 4: the load value is clamped, and load beats enable
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd13);
    checkOutput("t4_clamp", 32'(cnt[0]), 32'd9);
    checkOutput("t4_noclamp16", 32'(cnt[2]), 32'd13);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    checkOutput("t4_load_wins", 32'(cnt[0]), 32'd5);

    // Scenario 5: clear beats load and enable, then counting resumes from 0
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd6);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd6);
    checkOutput("t5_clear_wins", 32'(cnt[0]), 32'd0);
    checkOutput("t5_clear_wrap", 32'(wr[0]), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checkOutput("t5_resume", 32'(cnt[0]), 32'd1);

    // Scenario 6: full-range dut2 toggling direction wraps every cycle
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd15);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b1, k[0], 1'b0, 4'd0);
      checkOutput("t6_toggle", 32'(cnt[2]), k[0] ? 32'd15 : 32'd0);
      checkOutput("t6_toggle_wrap", 32'(wr[2]), 32'd1);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      checkOutput("t6_hold", 32'(cnt[2]), 32'd15);
      checkOutput("t6_hold_wrap", 32'(wr[2]), 32'd0);
    end

    // Randomised traffic, checked by the per-cycle compare
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(($urandom_range(99) >= 3) ? 1'b1 : 1'b0,
                    ($urandom_range(99) < 70) ? 1'b1 : 1'b0,
                    1'($urandom_range(1)),
                    ($urandom_range(99) < 8) ? 1'b1 : 1'b0,
                    4'($urandom_range(15)));
    end

    @(posedge clk);
    #7;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
